// File: rtl/crtc_timing.sv
// Character/scanline timing generator: turns CRTC R0-R13 into sync, display
// enable, refresh address (MA) and raster address (RA), stepping once per char_en_i.
module crtc_timing #(
  parameter int MA_WIDTH = 14,
  parameter int RA_WIDTH = 5
) (
  input  logic                clock_i,
  input  logic                reset_n_i,
  input  logic                char_en_i,
  input  logic [7:0]          r0_h_total_i,
  input  logic [7:0]          r1_h_displayed_i,
  input  logic [7:0]          r2_h_sync_pos_i,
  input  logic [7:0]          r3_sync_width_i,
  input  logic [6:0]          r4_v_total_i,
  input  logic [4:0]          r5_v_adjust_i,
  input  logic [6:0]          r6_v_displayed_i,
  input  logic [6:0]          r7_v_sync_pos_i,
  input  logic [4:0]          r9_max_scan_line_i,
  input  logic [5:0]          r12_start_addr_hi_i,
  input  logic [7:0]          r13_start_addr_lo_i,
  output logic                h_sync_o,
  output logic                v_sync_o,
  output logic                display_en_o,
  output logic [MA_WIDTH-1:0] ma_o,
  output logic [RA_WIDTH-1:0] ra_o,
  output logic                frame_start_o
);

  typedef enum logic {ST_ROWS = 1'b0, ST_ADJUST = 1'b1} state_t;

  state_t                state_q, state_d;
  logic                  first_q, first_d;
  logic [7:0]            h_cnt_q, h_cnt_d;
  logic [RA_WIDTH-1:0]   ra_cnt_q, ra_cnt_d;
  logic [RA_WIDTH-1:0]   adj_cnt_q, adj_cnt_d;
  logic [6:0]            row_cnt_q, row_cnt_d;
  logic [3:0]            hs_cnt_q, hs_cnt_d;
  logic [4:0]            vs_cnt_q, vs_cnt_d;
  logic [MA_WIDTH-1:0]   ma_row_q, ma_row_d;
  logic                  new_frame, line_start;

  logic                  h_sync_q, h_sync_d;
  logic                  v_sync_q, v_sync_d;
  logic                  display_en_q, display_en_d;
  logic [MA_WIDTH-1:0]   ma_q, ma_d;
  logic [RA_WIDTH-1:0]   ra_q, ra_d;
  logic                  frame_start_q, frame_start_d;

  // State register
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= ST_ROWS;
    else            state_q <= state_d;
  end

  // Counters and position advance; the vertical FSM steps only at end of line.
  // first_q makes the first strobe after reset present position 0 as a frame start
  // instead of advancing past it.
  always_comb begin
    state_d    = state_q;
    first_d    = first_q;
    h_cnt_d    = h_cnt_q;
    ra_cnt_d   = ra_cnt_q;
    adj_cnt_d  = adj_cnt_q;
    row_cnt_d  = row_cnt_q;
    hs_cnt_d   = hs_cnt_q;
    vs_cnt_d   = vs_cnt_q;
    ma_row_d   = ma_row_q;
    new_frame  = 1'b0;
    line_start = 1'b0;
    if (char_en_i) begin
      if (first_q) begin
        first_d    = 1'b0;
        new_frame  = 1'b1;
        line_start = 1'b1;
      end else if (h_cnt_q == r0_h_total_i) begin
        h_cnt_d    = '0;
        line_start = 1'b1;
        case (state_q)
          ST_ROWS: begin
            if (ra_cnt_q != RA_WIDTH'(r9_max_scan_line_i)) begin
              ra_cnt_d = ra_cnt_q + 1'b1;
            end else begin
              ra_cnt_d = '0;
              if (row_cnt_q != r4_v_total_i) begin
                row_cnt_d = row_cnt_q + 1'b1;
                ma_row_d  = ma_row_q + MA_WIDTH'(r1_h_displayed_i);
              end else if (r5_v_adjust_i == 5'd0) begin
                new_frame = 1'b1;
              end else begin
                state_d   = ST_ADJUST;
                adj_cnt_d = '0;
              end
            end
          end
          default: begin
            if (adj_cnt_q == RA_WIDTH'(r5_v_adjust_i - 5'd1)) begin
              new_frame = 1'b1;
            end else begin
              adj_cnt_d = adj_cnt_q + 1'b1;
              ra_cnt_d  = ra_cnt_q + 1'b1;
            end
          end
        endcase
      end else begin
        h_cnt_d = h_cnt_q + 8'd1;
      end

      if (new_frame) begin
        state_d   = ST_ROWS;
        row_cnt_d = '0;
        ra_cnt_d  = '0;
        adj_cnt_d = '0;
        ma_row_d  = MA_WIDTH'({r12_start_addr_hi_i, r13_start_addr_lo_i});
      end

      if (h_cnt_d == r2_h_sync_pos_i)
        hs_cnt_d = r3_sync_width_i[3:0];
      else if (hs_cnt_q != 4'd0)
        hs_cnt_d = hs_cnt_q - 4'd1;

      // vsync width counts scanlines, so it only moves at line starts
      if (line_start) begin
        if (state_d == ST_ROWS && row_cnt_d == r7_v_sync_pos_i && ra_cnt_d == '0)
          vs_cnt_d = (r3_sync_width_i[7:4] == 4'd0) ? 5'd16 : {1'b0, r3_sync_width_i[7:4]};
        else if (vs_cnt_q != 5'd0)
          vs_cnt_d = vs_cnt_q - 5'd1;
      end
    end
  end

  // Output decode from the post-update position
  always_comb begin
    h_sync_d      = h_sync_q;
    v_sync_d      = v_sync_q;
    display_en_d  = display_en_q;
    ma_d          = ma_q;
    ra_d          = ra_q;
    frame_start_d = new_frame;
    if (char_en_i) begin
      h_sync_d     = (hs_cnt_d != 4'd0);
      v_sync_d     = (vs_cnt_d != 5'd0);
      display_en_d = (h_cnt_d < r1_h_displayed_i) && (row_cnt_d < r6_v_displayed_i)
                     && (state_d == ST_ROWS);
      ma_d         = ma_row_d + MA_WIDTH'(h_cnt_d);
      ra_d         = ra_cnt_d;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      first_q       <= 1'b1;
      h_cnt_q       <= '0;
      ra_cnt_q      <= '0;
      adj_cnt_q     <= '0;
      row_cnt_q     <= '0;
      hs_cnt_q      <= '0;
      vs_cnt_q      <= '0;
      ma_row_q      <= '0;
      h_sync_q      <= 1'b0;
      v_sync_q      <= 1'b0;
      display_en_q  <= 1'b0;
      ma_q          <= '0;
      ra_q          <= '0;
      frame_start_q <= 1'b0;
    end else begin
      first_q       <= first_d;
      h_cnt_q       <= h_cnt_d;
      ra_cnt_q      <= ra_cnt_d;
      adj_cnt_q     <= adj_cnt_d;
      row_cnt_q     <= row_cnt_d;
      hs_cnt_q      <= hs_cnt_d;
      vs_cnt_q      <= vs_cnt_d;
      ma_row_q      <= ma_row_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      display_en_q  <= display_en_d;
      ma_q          <= ma_d;
      ra_q          <= ra_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign h_sync_o      = h_sync_q;
  assign v_sync_o      = v_sync_q;
  assign display_en_o  = display_en_q;
  assign ma_o          = ma_q;
  assign ra_o          = ra_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_crtc_timing.sv
// Directed bench for crtc_timing: expected outputs come from the programmed
// frame geometry (line/char position of each strobe), not from the DUT.
module tb_crtc_timing;

  logic        clock_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        char_en_i = 1'b0;
  logic [7:0]  r0, r1, r2, r3, r13;
  logic [6:0]  r4, r6, r7;
  logic [4:0]  r5, r9;
  logic [5:0]  r12;
  logic        h_sync_o, v_sync_o, display_en_o, frame_start_o;
  logic [13:0] ma_o;
  logic [4:0]  ra_o;

  int checks = 0;
  int errors = 0;

  crtc_timing #(.MA_WIDTH(14), .RA_WIDTH(5)) dut (
    .clock_i             (clock_i),
    .reset_n_i           (reset_n_i),
    .char_en_i           (char_en_i),
    .r0_h_total_i        (r0),
    .r1_h_displayed_i    (r1),
    .r2_h_sync_pos_i     (r2),
    .r3_sync_width_i     (r3),
    .r4_v_total_i        (r4),
    .r5_v_adjust_i       (r5),
    .r6_v_displayed_i    (r6),
    .r7_v_sync_pos_i     (r7),
    .r9_max_scan_line_i  (r9),
    .r12_start_addr_hi_i (r12),
    .r13_start_addr_lo_i (r13),
    .h_sync_o            (h_sync_o),
    .v_sync_o            (v_sync_o),
    .display_en_o        (display_en_o),
    .ma_o                (ma_o),
    .ra_o                (ra_o),
    .frame_start_o       (frame_start_o)
  );

  always #8 clock_i = ~clock_i;

  task automatic chk(input string tag, input int n, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @step %0d: got %0h expected %0h", tag, n, obs, exp);
    end
  endtask

  // One idle clock, then a one-clock char_en strobe; returns on the negedge after it
  task automatic step();
    @(negedge clock_i);
    char_en_i = 1'b1;
    @(negedge clock_i);
    char_en_i = 1'b0;
  endtask

  task automatic do_reset();
    char_en_i = 1'b0;
    reset_n_i = 1'b0;
    repeat (2) @(negedge clock_i);
    reset_n_i = 1'b1;
  endtask

  task automatic set_t1();
    r0 = 8'd9; r1 = 8'd6; r2 = 8'd7; r3 = 8'h21; r4 = 7'd3; r5 = 5'd2;
    r6 = 7'd2; r7 = 7'd2; r9 = 5'd1; r12 = 6'h00; r13 = 8'h10;
  endtask

  // Geometry of set_t1: 10 chars/line, rows 0..3 of 2 lines, then 2 adjust lines
  task automatic check_t1(input int n, input logic [13:0] base, input bit hs_en);
    int p, line, h, row, ra;
    p    = n % 100;
    line = p / 10;
    h    = p % 10;
    row  = (line < 8) ? line / 2 : 3;
    ra   = (line < 8) ? line % 2 : line - 8;
    chk("frame_start", n, frame_start_o, (p == 0));
    chk("h_sync", n, h_sync_o, hs_en && (h == 7));
    chk("v_sync", n, v_sync_o, (line == 4 || line == 5));
    chk("display_en", n, display_en_o, (h < 6) && (line < 4));
    chk("ra", n, ra_o, ra);
    chk("ma", n, ma_o, (base + 14'(6 * row + h)) & 14'h3FFF);
  endtask

  initial begin
    int hs_cnt_seen;
    int de_cnt_seen;
    int line, f;
    set_t1();

    // Reset state
    reset_n_i = 1'b0;
    repeat (2) @(negedge clock_i);
    chk("rst_h_sync", 0, h_sync_o, 0);
    chk("rst_v_sync", 0, v_sync_o, 0);
    chk("rst_de", 0, display_en_o, 0);
    chk("rst_ma", 0, ma_o, 0);
    chk("rst_ra", 0, ra_o, 0);
    chk("rst_frame_start", 0, frame_start_o, 0);
    reset_n_i = 1'b1;

    // Frame geometry, sync and MA/RA over three frames
    hs_cnt_seen = 0;
    de_cnt_seen = 0;
    for (int n = 0; n < 300; n++) begin
      step();
      check_t1(n, 14'h010, 1'b1);
      hs_cnt_seen += int'(h_sync_o);
      de_cnt_seen += int'(display_en_o);
      if (n == 0) begin
        @(negedge clock_i);
        chk("frame_start_clear", n, frame_start_o, 0);
      end
    end
    chk("hsync_total", 300, hs_cnt_seen, 30);
    chk("de_total", 300, de_cnt_seen, 72);

    // vsync width 0 means 16 lines; 22-line frame so the pulse crosses the wrap
    do_reset();
    r0 = 8'd3; r1 = 8'd2; r2 = 8'd1; r3 = 8'h01; r4 = 7'd9; r5 = 5'd2;
    r6 = 7'd1; r7 = 7'd8; r9 = 5'd1; r12 = 6'h00; r13 = 8'h00;
    for (int n = 0; n < 176; n++) begin
      step();
      f    = n / 88;
      line = (n % 88) / 4;
      chk("vs16", n, v_sync_o, (line >= 16) || (f == 1 && line < 10));
      chk("vs16_fs", n, frame_start_o, (n % 88 == 0));
    end

    // hsync width 0: never asserted, everything else unchanged
    do_reset();
    set_t1();
    r3 = 8'h20;
    hs_cnt_seen = 0;
    for (int n = 0; n < 100; n++) begin
      step();
      check_t1(n, 14'h010, 1'b0);
      hs_cnt_seen += int'(h_sync_o);
    end
    chk("hs0_total", 100, hs_cnt_seen, 0);

    // No vertical adjust: 8 lines x 10 chars = 80-strobe frame
    do_reset();
    set_t1();
    r5 = 5'd0;
    for (int n = 0; n < 161; n++) begin
      step();
      line = (n % 80) / 10;
      chk("r5z_fs", n, frame_start_o, (n % 80 == 0));
      chk("r5z_ra", n, ra_o, line % 2);
      chk("r5z_ma", n, ma_o, 14'h010 + 14'(6 * (line / 2) + (n % 10)));
    end

    // MA wrap at 2^14 from start address 0x3FFC
    do_reset();
    set_t1();
    r12 = 6'h3F; r13 = 8'hFC;
    for (int n = 0; n < 30; n++) begin
      step();
      check_t1(n, 14'h3FFC, 1'b1);
    end
    chk("wrap_row1_base", 30, ma_o, 14'h0002 + 14'd9);

    // Start address only sampled at frame start
    do_reset();
    set_t1();
    for (int n = 0; n < 130; n++) begin
      if (n == 31) r13 = 8'h40;
      step();
      check_t1(n, (n < 100) ? 14'h010 : 14'h040, 1'b1);
    end

    // Asynchronous reset mid-hsync/vsync
    do_reset();
    set_t1();
    for (int n = 0; n < 48; n++) begin
      step();
      check_t1(n, 14'h010, 1'b1);
    end
    chk("pre_rst_hs", 47, h_sync_o, 1);
    chk("pre_rst_vs", 47, v_sync_o, 1);
    #3 reset_n_i = 1'b0;
    #1;
    chk("arst_h_sync", 48, h_sync_o, 0);
    chk("arst_v_sync", 48, v_sync_o, 0);
    chk("arst_de", 48, display_en_o, 0);
    chk("arst_ma", 48, ma_o, 0);
    chk("arst_ra", 48, ra_o, 0);
    chk("arst_frame_start", 48, frame_start_o, 0);
    @(negedge clock_i);
    reset_n_i = 1'b1;
    for (int n = 0; n < 12; n++) begin
      step();
      check_t1(n, 14'h010, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/crtc_timing.md
Name: crtc_timing

Overview:
- Character/scanline timing generator for the PET video path. It is the stage directly downstream of the CRTC register file.
- Consumes the R0–R13 values held in that register file and produces hsync, vsync, display enable, the 14-bit refresh memory address (MA) and the raster address (RA).
- The video fetch/shift logic consumes MA/RA to read VRAM and VROM.
- Advances only on a one-cycle character-clock enable derived from the 64 MHz system clock.

Parameters:
- MA_WIDTH, 14, refresh memory address width.
- RA_WIDTH, 5, raster (scanline-in-row) counter width.

Ports:
- clock_i  in  1  system clock, 64 MHz.
- reset_n_i  in  1  asynchronous active-low reset.
- char_en_i  in  1  one-cycle strobe; one character time elapses per strobe.
- r0_h_total_i  in  8  horizontal total minus one.
- r1_h_displayed_i  in  8  displayed characters per line.
- r2_h_sync_pos_i  in  8  hsync start character.
- r3_sync_width_i  in  8  [3:0] hsync width in chars, [7:4] vsync width in lines.
- r4_v_total_i  in  7  character rows minus one.
- r5_v_adjust_i  in  5  extra scanlines after the last row.
- r6_v_displayed_i  in  7  displayed character rows.
- r7_v_sync_pos_i  in  7  vsync start row.
- r9_max_scan_line_i  in  5  scanlines per row minus one.
- r12_start_addr_hi_i  in  6  start address [13:8].
- r13_start_addr_lo_i  in  8  start address [7:0].
- h_sync_o  out  1  horizontal sync, active high.
- v_sync_o  out  1  vertical sync, active high.
- display_en_o  out  1  active display region.
- ma_o  out  14  refresh memory address.
- ra_o  out  5  raster address.
- frame_start_o  out  1  one-cycle pulse at character 0, line 0 of a frame.

Behaviour:
- All state updates on rising clock_i, and only in cycles where char_en_i=1, except frame_start_o, which clears in the next cycle.
- Outputs are registered: they reflect the counter values after the update.
- Reset (async assert, sync release): h_cnt, ra_cnt, row_cnt, adj_cnt, hs_cnt, vs_cnt, ma_row and all outputs = 0; state = ROWS.
  - The first char_en_i after reset processes position h=0,row=0,ra=0 as a frame start.
- Horizontal counter:
  - h_cnt counts 0..R0; when h_cnt==R0 it wraps to 0 (end of line).
  - R0=0 means every character is end-of-line.
- hsync:
  - Asserts at the char_en where h_cnt becomes R2; hs_cnt loads R3[3:0].
  - Deasserts after R3[3:0] characters.
  - R3[3:0]=0 means hsync is never asserted.
  - If R2>R0, hsync never fires.
- Vertical state machine, evaluated at end-of-line:
  - ROWS state:
    - If ra_cnt!=R9: ra_cnt++.
    - Else ra_cnt=0, then:
      - If row_cnt!=R4: row_cnt++ and ma_row += R1, mod 2^14.
      - Else if R5==0: new frame.
      - Else: go to ADJUST with adj_cnt=0.
  - ADJUST state:
    - ra_cnt counts 0..R5-1. When adj_cnt==R5-1: new frame.
- New frame:
  - row_cnt=0, ra_cnt=0, state=ROWS.
  - ma_row latched from {R12[5:0],R13}; the start address is sampled only here.
  - frame_start_o pulses for one clock.
- vsync:
  - Asserts at the start of the line where state==ROWS, row_cnt==R7 and ra_cnt==0.
  - vs_cnt loads R3[7:4], where 0 means 16.
  - Deasserts after that many scanlines, counted at end-of-line.
  - It may span into ADJUST or across a frame wrap; it still completes its full count.
- display_en_o = (h_cnt < R1) && (row_cnt < R6) && state==ROWS.
  - R1=0 or R6=0 means never enabled.
- ma_o = ma_row + h_cnt, mod 2^14, in all regions, including blanking.
- ra_o = ra_cnt.
- Register changes mid-frame take effect at the next comparison, with no resynchronisation.
  - Exception: if h_cnt>R0 after R0 shrinks, the comparison is equality-only, so h_cnt continues to 255, wraps to 0 mod 256, and then behaves normally.
  - The same equality rule applies to row_cnt vs R4 and ra_cnt vs R9.
- Reset mid-frame: all state clears immediately; no partial sync pulse continues.

Test Plan:
1. Frame geometry and sync. Program R0=9, R1=6, R2=7, R3=0x21, R4=3, R5=2, R6=2, R7=2, R9=1, R12=0, R13=0x10; run 300 char_en.
   - frame_start_o every 100 char_en.
   - h_sync_o high for h_cnt 7 only, once per 10 chars.
   - v_sync_o high for exactly 2 lines starting row 2, ra 0.
   - display_en_o high for 6 chars × 4 lines per frame.
2. MA/RA sequence with the same settings:
   - row 0: ma_o 0x010..0x019, ra_o 0 then 1.
   - row 1: ma_o starts 0x016.
   - adjust lines: ra_o 0,1 and ma_o continues from row 3 base 0x022.
3. Edge values:
   - R3[7:4]=0 → vsync lasts 16 lines, crossing the frame wrap.
   - R3[3:0]=0 → h_sync_o never asserts.
   - R5=0 → frame is 80 char_en.
4. Wrap-around: R12=0x3F, R13=0xFC, R1=6 → ma_o goes 0x3FFC..0x3FFF, 0x0000, 0x0001 on row 0.
5. Start address latching: change R13 mid-frame → ma_o unchanged until the next frame_start_o, then uses the new base.
6. Reset: assert reset_n_i low mid-hsync/vsync, asynchronously without clock → all outputs 0 immediately. After release, the first char_en produces frame_start_o=1 and ma_o equal to the start address.
